// File: rtl/enc_result_fifo.sv
// enc_result_fifo: buffers valid priority-encoder results in a first-word-
// fall-through FIFO toward a ready/valid consumer. Also keeps saturating
// per-index hit counters and a counter of results dropped while full.
module enc_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 enc_q,
  input  logic                       enc_valid,
  input  logic                       clr,
  output logic [1:0]                 out_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic [4*CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]           ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] hit_q [4];
  logic [CNT_W-1:0] hit_d [4];
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [1:0]       mem [DEPTH];

  logic pop;
  logic push;
  logic drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Handshake decode and next-state computation for pointers, level and counters
  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid & out_ready;
    push      = enc_valid & (~full | pop);
    drop      = enc_valid & full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Index compare is gated by enc_valid first so an X on enc_q never reaches state
    for (int i = 0; i < 4; i++) begin
      hit_d[i] = hit_q[i];
      if (clr)
        hit_d[i] = '0;
      else if (enc_valid && (enc_q == 2'(i)))
        hit_d[i] = sat_inc(hit_q[i]);
    end

    ovf_d = ovf_q;
    if (clr)
      ovf_d = '0;
    else if (drop)
      ovf_d = sat_inc(ovf_q);
  end

  // Control state and counters, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= '0;
      for (int i = 0; i < 4; i++) hit_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      for (int i = 0; i < 4; i++) hit_q[i] <= hit_d[i];
    end
  end

  // Entry storage; not reset, only ever read while the entry is occupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= enc_q;
  end

  // Head is forced to 0 when empty so stale or uninitialised storage is never visible
  always_comb begin
    out_idx = out_valid ? mem[rd_ptr_q] : 2'b00;
    level   = level_q;
    ovf_cnt = ovf_q;
    for (int i = 0; i < 4; i++) hit_cnt[i*CNT_W +: CNT_W] = hit_q[i];
  end

endmodule
